// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared multiply/divide unit types and constants
package mdu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_LAT = 34;
  localparam int DIV_W   = 32;

endpackage

// File: rtl/div_radix2.sv
// rtl/div_radix2.sv - 32-step restoring radix-2 divider, signed/unsigned, latches own operands
module div_radix2
  import mdu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  input  logic               flush,
  input  logic               sign,
  input  logic [DIV_W-1:0]   a,
  input  logic [DIV_W-1:0]   b,
  output logic               stall,
  output logic [2*DIV_W-1:0] result
);

  logic             running;
  logic [5:0]       cnt;
  logic [DIV_W-1:0] rem;
  logic [DIV_W-1:0] quo;
  logic [DIV_W-1:0] dvs;
  logic [DIV_W-1:0] a_keep;
  logic             q_neg;
  logic             r_neg;
  logic             b_zero;

  logic [DIV_W-1:0] a_mag;
  logic [DIV_W-1:0] b_mag;
  logic [DIV_W:0]   rem_sh;
  logic [DIV_W:0]   diff;
  logic             ge;

  // Operand magnitudes and one restoring step on the working registers
  always_comb begin
    a_mag  = (sign && a[DIV_W-1]) ? (~a + 1'b1) : a;
    b_mag  = (sign && b[DIV_W-1]) ? (~b + 1'b1) : b;
    rem_sh = {rem, quo[DIV_W-1]};
    diff   = rem_sh - {1'b0, dvs};
    ge     = ~diff[DIV_W];
  end

  // Launch latches operands; each running cycle retires one quotient bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      a_keep  <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      b_zero  <= 1'b0;
    end else if (flush) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (valid && !running) begin
      running <= 1'b1;
      cnt     <= 6'd32;
      rem     <= '0;
      quo     <= a_mag;
      dvs     <= b_mag;
      a_keep  <= a;
      q_neg   <= sign & (a[DIV_W-1] ^ b[DIV_W-1]);
      r_neg   <= sign & a[DIV_W-1];
      b_zero  <= (b == '0);
    end else if (running) begin
      rem     <= ge ? diff[DIV_W-1:0] : rem_sh[DIV_W-1:0];
      quo     <= {quo[DIV_W-2:0], ge};
      cnt     <= cnt - 6'd1;
      running <= (cnt != 6'd1);
    end
  end

  // Sign fix-up; a zero divisor returns the dividend as remainder and zero quotient
  always_comb begin
    stall = running;
    if (b_zero) begin
      result = {a_keep, {DIV_W{1'b0}}};
    end else begin
      result = {(r_neg ? (~rem + 1'b1) : rem), (q_neg ? (~quo + 1'b1) : quo)};
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - EX-stage divide sequencer; optional DIV_ZERO_FAST_EN bypasses divider on zero divisor
module div_issue_ctrl
  import mdu_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  input  logic             req_sign,
  input  logic [DIV_W-1:0] req_a,
  input  logic [DIV_W-1:0] req_b,
  input  logic             ex_flush,
  input  logic             ex_adv,
  output logic             div_stall,
  output logic             hilo_we,
  output logic [DIV_W-1:0] hi_out,
  output logic [DIV_W-1:0] lo_out,
  output logic             busy
);

  div_state_t         state;
  div_state_t         next_state;
  logic               div_valid;
  logic               div_flush;
  logic               div_busy;
  logic               capture;
  logic [2*DIV_W-1:0] div_result;
`ifdef DIV_ZERO_FAST_EN
  logic               fast_cap;
`endif

  div_radix2 u_div (
    .clk    (clk),
    .rst    (~resetn),
    .valid  (div_valid),
    .flush  (div_flush),
    .sign   (req_sign),
    .a      (req_a),
    .b      (req_b),
    .stall  (div_busy),
    .result (div_result)
  );

  // State register and result capture; results only change on completion
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      state <= next_state;
      if (capture) begin
        hi_out <= div_result[2*DIV_W-1:DIV_W];
        lo_out <= div_result[DIV_W-1:0];
      end
`ifdef DIV_ZERO_FAST_EN
      else if (fast_cap) begin
        hi_out <= req_a;
        lo_out <= '0;
      end
`endif
    end
  end

  // Next state, launch/flush of the divider, stall and write strobe
  always_comb begin
    next_state = state;
    div_valid  = 1'b0;
    div_flush  = 1'b0;
    div_stall  = 1'b0;
    hilo_we    = 1'b0;
    capture    = 1'b0;
    busy       = (state == BUSY);
`ifdef DIV_ZERO_FAST_EN
    fast_cap   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (resetn && req_valid && !ex_flush) begin
          div_stall = 1'b1;
`ifdef DIV_ZERO_FAST_EN
          if (req_b == '0) begin
            fast_cap   = 1'b1;
            next_state = DONE;
          end else begin
            div_valid  = 1'b1;
            next_state = BUSY;
          end
`else
          div_valid  = 1'b1;
          next_state = BUSY;
`endif
        end
      end
      BUSY: begin
        div_stall = 1'b1;
        if (ex_flush) begin
          div_flush  = 1'b1;
          next_state = IDLE;
        end else if (!div_busy) begin
          capture    = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        // Flush beats advance; req_valid is ignored so nothing relaunches
        if (ex_flush) begin
          next_state = IDLE;
        end else if (ex_adv) begin
          hilo_we    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - scoreboard bench for div_issue_ctrl
module tb_div_issue_ctrl;
  import mdu_pkg::*;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic        req_sign;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        ex_flush;
  logic        ex_adv;
  logic        div_stall;
  logic        hilo_we;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;

  int n_checks;
  int n_fail;
  logic [63:0] exp_q[$];

  div_issue_ctrl dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_sign  (req_sign),
    .req_a     (req_a),
    .req_b     (req_b),
    .ex_flush  (ex_flush),
    .ex_adv    (ex_adv),
    .div_stall (div_stall),
    .hilo_we   (hilo_we),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request, counts stall cycles, holds DONE for 'hold' cycles, then advances
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int hold, input bit do_alt, input logic [31:0] alt_a,
                        output int stall_n, output int we_n, output int relaunch,
                        output logic [31:0] hi_c, output logic [31:0] lo_c);
    @(posedge clk); #1;
    req_valid = 1'b1; req_a = a; req_b = b; req_sign = s; ex_adv = 1'b0; ex_flush = 1'b0;
    stall_n = 0; we_n = 0; relaunch = 0; hi_c = 'x; lo_c = 'x;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (div_stall) stall_n++; else break;
      if (do_alt && stall_n == 5) req_a = alt_a;
    end
    for (int i = 0; i < hold; i++) begin
      if (busy || div_stall) relaunch++;
      if (hilo_we) we_n++;
      @(negedge clk);
    end
    ex_adv = 1'b1;
    #1;
    if (hilo_we) begin
      we_n++; hi_c = hi_out; lo_c = lo_out;
    end
    @(posedge clk); #1;
    ex_adv = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (hilo_we) we_n++;
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0; req_valid = 1'b0; req_sign = 1'b0; req_a = '0; req_b = '0;
    ex_flush = 1'b0; ex_adv = 1'b0;
    #2;
    n_checks++; if (div_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", div_stall); end
    n_checks++; if (hilo_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b exp 0", hilo_we); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if ({hi_out, lo_out} !== 64'd0) begin n_fail++; $display("FAIL reset_hilo got %h exp 0", {hi_out, lo_out}); end
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic test_divu;
    int st, we, rl; logic [31:0] h, l; logic [63:0] e;
    exp_q.push_back({32'd2, 32'd14});
    run_op(32'd100, 32'd7, 1'b0, 0, 1'b0, '0, st, we, rl, h, l);
    e = exp_q.pop_front();
    n_checks++; if (st !== DIV_LAT) begin n_fail++; $display("FAIL divu_stall got %0d exp %0d", st, DIV_LAT); end
    n_checks++; if (we !== 1) begin n_fail++; $display("FAIL divu_we_pulses got %0d exp 1", we); end
    n_checks++; if ({h, l} !== e) begin n_fail++; $display("FAIL divu_result got %h exp %h", {h, l}, e); end
  endtask

  task automatic test_div_signed;
    int st, we, rl; logic [31:0] h, l; logic [63:0] e;
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 1'b1, 32'h55, st, we, rl, h, l);
    e = exp_q.pop_front();
    n_checks++; if ({h, l} !== e) begin n_fail++; $display("FAIL div_neg_result got %h exp %h", {h, l}, e); end
    n_checks++; if (st !== DIV_LAT) begin n_fail++; $display("FAIL div_neg_stall got %0d exp %0d", st, DIV_LAT); end
    exp_q.push_back({32'd1, 32'hFFFF_FFFD});
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0, 1'b0, '0, st, we, rl, h, l);
    e = exp_q.pop_front();
    n_checks++; if ({h, l} !== e) begin n_fail++; $display("FAIL div_negb_result got %h exp %h", {h, l}, e); end
  endtask

  task automatic test_flush;
    int st, we, rl, we_fl; logic [31:0] h, l; logic [63:0] e;
    we_fl = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_a = 32'd1000; req_b = 32'd3; req_sign = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); if (hilo_we) we_fl++;
      @(posedge clk); #1;
    end
    ex_flush = 1'b1;
    @(negedge clk);
    if (hilo_we) we_fl++;
    n_checks++; if (div_stall !== 1'b1) begin n_fail++; $display("FAIL flush_stall_t10 got %b exp 1", div_stall); end
    @(posedge clk); #1;
    ex_flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    if (hilo_we) we_fl++;
    n_checks++; if (div_stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall_t11 got %b exp 0", div_stall); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy_t11 got %b exp 0", busy); end
    n_checks++; if (we_fl !== 0) begin n_fail++; $display("FAIL flush_no_write got %0d exp 0", we_fl); end
    exp_q.push_back({32'd0, 32'd3});
    run_op(32'd9, 32'd3, 1'b0, 0, 1'b0, '0, st, we, rl, h, l);
    e = exp_q.pop_front();
    n_checks++; if ({h, l} !== e) begin n_fail++; $display("FAIL flush_next_result got %h exp %h", {h, l}, e); end
    n_checks++; if (st !== DIV_LAT) begin n_fail++; $display("FAIL flush_next_stall got %0d exp %0d", st, DIV_LAT); end
  endtask

  task automatic test_hold_done;
    int st, we, rl; logic [31:0] h, l; logic [63:0] e;
    exp_q.push_back({32'd0, 32'd10});
    run_op(32'd50, 32'd5, 1'b0, 5, 1'b0, '0, st, we, rl, h, l);
    e = exp_q.pop_front();
    n_checks++; if (rl !== 0) begin n_fail++; $display("FAIL hold_relaunch got %0d exp 0", rl); end
    n_checks++; if (we !== 1) begin n_fail++; $display("FAIL hold_we_pulses got %0d exp 1", we); end
    n_checks++; if ({h, l} !== e) begin n_fail++; $display("FAIL hold_result got %h exp %h", {h, l}, e); end
  endtask

  task automatic test_div_zero;
    int st, we, rl, exp_st; logic [31:0] h, l; logic [63:0] e;
`ifdef DIV_ZERO_FAST_EN
    exp_st = 1;
`else
    exp_st = DIV_LAT;
`endif
    exp_q.push_back({32'h1234, 32'd0});
    run_op(32'h1234, 32'd0, 1'b0, 0, 1'b0, '0, st, we, rl, h, l);
    e = exp_q.pop_front();
    n_checks++; if ({h, l} !== e) begin n_fail++; $display("FAIL divzero_result got %h exp %h", {h, l}, e); end
    n_checks++; if (st !== exp_st) begin n_fail++; $display("FAIL divzero_stall got %0d exp %0d", st, exp_st); end
  endtask

  task automatic test_reset_midop;
    int st, we, rl; logic [31:0] h, l; logic [63:0] e;
    @(posedge clk); #1;
    req_valid = 1'b1; req_a = 32'd77; req_b = 32'd5; req_sign = 1'b0;
    for (int i = 0; i < 20; i++) begin @(posedge clk); #1; end
    resetn = 1'b0; req_valid = 1'b0;
    #1;
    n_checks++; if (div_stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall got %b exp 0", div_stall); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
    n_checks++; if (hilo_we !== 1'b0) begin n_fail++; $display("FAIL rst_mid_we got %b exp 0", hilo_we); end
    n_checks++; if ({hi_out, lo_out} !== 64'd0) begin n_fail++; $display("FAIL rst_mid_hilo got %h exp 0", {hi_out, lo_out}); end
    @(posedge clk); #1;
    resetn = 1'b1;
    exp_q.push_back({32'd2, 32'd22});
    run_op(32'd200, 32'd9, 1'b0, 0, 1'b0, '0, st, we, rl, h, l);
    e = exp_q.pop_front();
    n_checks++; if (st !== DIV_LAT) begin n_fail++; $display("FAIL rst_after_stall got %0d exp %0d", st, DIV_LAT); end
    n_checks++; if ({h, l} !== e) begin n_fail++; $display("FAIL rst_after_result got %h exp %h", {h, l}, e); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_divu();
    test_div_signed();
    test_flush();
    test_hold_done();
    test_div_zero();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

Sequencing controller for the EX-stage radix-2 divider of the pipelined MIPS core. It accepts DIV/DIVU requests from EX, launches the divider exactly once per instruction, and holds the pipeline stall for the divide's duration. It captures quotient/remainder into output registers and issues the HI/LO write only when the instruction actually leaves EX. Pipeline flushes cancel an in-flight divide cleanly.

## Interface
- No parameters.
- `clk`  in  1  core clock
- `resetn`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  EX holds a DIV/DIVU instruction
- `req_sign`  in  1  1 = DIV (signed), 0 = DIVU
- `req_a`  in  32  dividend (forwarded value, may change while stalled)
- `req_b`  in  32  divisor
- `ex_flush`  in  1  EX instruction killed this cycle (exception/eret)
- `ex_adv`  in  1  EX instruction moves to MEM this cycle
- `div_stall`  out  1  stall request to hazard unit
- `hilo_we`  out  1  HI/LO write strobe, one cycle
- `hi_out`  out  32  remainder
- `lo_out`  out  32  quotient
- `busy`  out  1  divider in flight (state BUSY)

## Operation
- States: IDLE, BUSY, DONE. Reset: IDLE; `hi_out`/`lo_out` = 0; `div_stall`, `hilo_we`, `busy` = 0.
- IDLE:
  - `req_valid & ~ex_flush` drives the inner launch: divider `valid` = 1 combinationally, with `a`/`b`/`sign` taken straight from `req_*`.
  - `div_stall` = 1 in the same cycle. Next state is BUSY.
  - Flush in the same cycle: no launch, no stall, stay IDLE.
- BUSY:
  - `div_stall` = 1 and `busy` = 1. The inner divider latches its own operands, so `req_*` changes are ignored.
  - Completion cycle is the first BUSY cycle with the inner stall low. On that cycle, register `{hi_out, lo_out}` = inner `result[63:32]`, `result[31:0]` and go to DONE.
  - `ex_flush` in BUSY: drive inner `flush` = 1, go to IDLE, no write, outputs unchanged.
- DONE:
  - `div_stall` = 0. The instruction may sit here while other hazards hold EX.
  - `req_valid` is ignored, so the same instruction never relaunches.
  - `hilo_we` = `ex_adv & ~ex_flush`, then go to IDLE.
  - `ex_flush` without `ex_adv`: go to IDLE, no write.
  - Otherwise stay in DONE with results held.
- Inner divider `rst` is driven by `~resetn`. Flush and reset abort the divide mid-operation with no partial write.
- Result semantics are the divider's:
  - Quotient rounds toward zero.
  - Remainder takes the dividend's sign.
  - Divisor 0 yields hi = `req_a`, lo = 0.

## Timing
- Request sampled in cycle t (IDLE). Inner counter runs from t+1 to t+32 and drops at t+33.
- Results are registered at the end of t+33.
- DONE from t+34: `div_stall` high for cycles t..t+33, exactly 34 cycles.
- Earliest `hilo_we` is t+34, when `ex_adv` is high in that cycle.
- Back-to-back divides: a new request is accepted in the IDLE cycle following the DONE→IDLE transition.
- `ex_flush` and `ex_adv` both high in DONE: flush wins, no write.

## Configuration
- `DIV_ZERO_FAST_EN` defined:
  - In IDLE, a request with `req_b` = 0 skips the divider and does not launch it.
  - Registers hi = `req_a`, lo = 0 and goes directly to DONE.
  - `div_stall` is high for 1 cycle (t only).
- Not defined: divisor 0 runs the full 34-cycle path, with identical results.

## Structure
- Shared package `mdu_pkg`:
  - state enum `div_state_t` {IDLE, BUSY, DONE}
  - constant `DIV_LAT` = 34
  - constant `DIV_W` = 32
- One sub-module: the existing `div_radix2`, instantiated once. The controller owns its `valid`, `flush`, `rst` and operand inputs.

## Test plan
- DIVU 100/7, `ex_adv` high at t+34: `div_stall` exactly 34 cycles, then hi = 2, lo = 14, `hilo_we` a single pulse.
- DIV −7/2 (0xFFFFFFF9 / 2): lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. In the same run, change `req_a` to 0x55 during BUSY: result is unchanged.
- `ex_flush` at t+10:
  - No `hilo_we`; `div_stall` drops at t+11.
  - A new request 9/3 at t+12 gives lo = 3, hi = 0.
- Hold `ex_adv` = 0 for 5 cycles in DONE with `req_valid` = 1: no relaunch (`busy` stays 0). `hilo_we` pulses only when `ex_adv` rises.
- Divisor 0, `req_a` = 0x1234:
  - Result is hi = 0x1234, lo = 0.
  - Stall is 34 cycles without `DIV_ZERO_FAST_EN`, 1 cycle with it.
- `resetn` low at t+20: all outputs 0 immediately, state IDLE. A request after release completes normally in 34 cycles.
